exe_stage: RTL and testbench

- Execute stage, directly downstream of the instruction decoder.
- Consumes the 4-bit execute command, write-back/memory enables, branch flag and S flag produced by decode (via the ID/EXE register).
- Performs the ALU operation, updates the NZCV status register and computes the branch target.
- Registers the results into the EXE/MEM pipeline register feeding the cache/memory stage.

---
 rtl/exe_pkg.sv | 24 ++
 rtl/alu.sv | 63 ++++++
 rtl/exe_stage.sv | 125 ++++++++++++
 tb/tb_exe_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU commands,
// NZCV bit positions and forwarding-select encodings.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam logic [1:0] FWD_ID  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus next NZCV.
// C and V pass through from cin/vin for logical and move ops.
module alu
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] val2,
    input  logic [3:0]       cmd,
    input  logic             cin,
    input  logic             vin,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       nzcv_next
);

    logic             is_sub;
    logic             arith;
    logic             c0;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;

    // Subtraction is rn + ~val2 + carry, so carry out is NOT borrow.
    always_comb begin
        is_sub = (cmd == CMD_SUB) || (cmd == CMD_SBC);
        arith  = is_sub || (cmd == CMD_ADD) || (cmd == CMD_ADC);
        b_op   = is_sub ? ~val2 : val2;
        unique case (cmd)
            CMD_ADC: c0 = cin;
            CMD_SUB: c0 = 1'b1;
            CMD_SBC: c0 = cin;
            default: c0 = 1'b0;
        endcase
        sum = {1'b0, rn} + {1'b0, b_op} + {{WIDTH{1'b0}}, c0};
    end

    always_comb begin
        unique case (cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD: res = sum[WIDTH-1:0];
            CMD_ADC: res = sum[WIDTH-1:0];
            CMD_SUB: res = sum[WIDTH-1:0];
            CMD_SBC: res = sum[WIDTH-1:0];
            CMD_AND: res = rn & val2;
            CMD_ORR: res = rn | val2;
            CMD_EOR: res = rn ^ val2;
            default: res = '0;
        endcase
    end

    always_comb begin
        nzcv_next        = '0;
        nzcv_next[FLG_N] = res[WIDTH-1];
        nzcv_next[FLG_Z] = (res == '0);
        nzcv_next[FLG_C] = arith ? sum[WIDTH] : cin;
        nzcv_next[FLG_V] = arith
            ? ((rn[WIDTH-1] == b_op[WIDTH-1]) &&
               (sum[WIDTH-1] != rn[WIDTH-1]))
            : vin;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV register, branch target, EXE/MEM register.
// Operand forwarding muxes are built when FORWARDING_EN is defined.
module exe_stage
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [3:0]       exe_cmd,
    input  logic             wb_en_in,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic             b_in,
    input  logic             s_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] val_rn,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [23:0]      imm24,
    input  logic [RA_W-1:0]  dest_in,
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [WIDTH-1:0] mem_fwd,
    input  logic [WIDTH-1:0] wb_fwd,
    output logic             valid_out,
    output logic             wb_en_out,
    output logic             mem_r_en_out,
    output logic             mem_w_en_out,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] st_val,
    output logic [RA_W-1:0]  dest_out,
    output logic [3:0]       status,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_addr
);

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] st_data;
    logic [WIDTH-1:0] res;
    logic [3:0]       nzcv_next;
    logic [WIDTH-1:0] br_off;
    logic             st_wr;

`ifdef FORWARDING_EN
    always_comb begin
        unique case (sel_src1)
            FWD_MEM: op1 = mem_fwd;
            FWD_WB:  op1 = wb_fwd;
            default: op1 = val_rn;
        endcase
        unique case (sel_src2)
            FWD_MEM: begin
                op2     = mem_fwd;
                st_data = mem_fwd;
            end
            FWD_WB: begin
                op2     = wb_fwd;
                st_data = wb_fwd;
            end
            default: begin
                op2     = val2;
                st_data = val_rm;
            end
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd, wb_fwd};
    assign op1        = val_rn;
    assign op2        = val2;
    assign st_data    = val_rm;
`endif

    alu #(.WIDTH(WIDTH)) u_alu (
        .rn        (op1),
        .val2      (op2),
        .cmd       (exe_cmd),
        .cin       (status[FLG_C]),
        .vin       (status[FLG_V]),
        .res       (res),
        .nzcv_next (nzcv_next)
    );

    // imm24 is a word offset; sign-extend and scale to bytes.
    assign br_off       = {{(WIDTH-26){imm24[23]}}, imm24, 2'b00};
    assign branch_addr  = pc_in + br_off;
    assign branch_taken = valid_in & b_in & ~flush;

    assign st_wr = valid_in & s_in & ~b_in & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= '0;
        end else if (!freeze && st_wr) begin
            status <= nzcv_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            alu_res      <= '0;
            st_val       <= '0;
            dest_out     <= '0;
        end else if (!freeze) begin
            valid_out    <= valid_in & ~flush;
            wb_en_out    <= wb_en_in & valid_in & ~flush;
            mem_r_en_out <= mem_r_en_in & valid_in & ~flush;
            mem_w_en_out <= mem_w_en_in & valid_in & ~flush;
            alu_res      <= res;
            st_val       <= st_data;
            dest_out     <= dest_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage; expected EXE/MEM contents are
// queued as each instruction is driven and checked one cycle later.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in;
    logic [3:0]  exe_cmd;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [31:0] pc_in, val_rn, val2, val_rm, mem_fwd, wb_fwd;
    logic [23:0] imm24;
    logic [3:0]  dest_in;
    logic [1:0]  sel_src1, sel_src2;
    logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] alu_res, st_val, branch_addr;
    logic [3:0]  dest_out, status;
    logic        branch_taken;

    typedef struct packed {
        logic        v, wb, mr, mw;
        logic        full;
        logic [31:0] res, st;
        logic [3:0]  dst, flags;
    } exp_t;

    exp_t        q[$];
    exp_t        last;
    logic [3:0]  m_status;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    exe_stage #(.WIDTH(32), .RA_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .exe_cmd(exe_cmd),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
        .pc_in(pc_in), .val_rn(val_rn), .val2(val2), .val_rm(val_rm),
        .imm24(imm24), .dest_in(dest_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
        .valid_out(valid_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_res(alu_res), .st_val(st_val), .dest_out(dest_out),
        .status(status), .branch_taken(branch_taken),
        .branch_addr(branch_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: wide unsigned/signed arithmetic.
    function automatic void model(input logic [3:0] cmd,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] st,
                                  output logic [31:0] r,
                                  output logic [3:0] nf);
        logic        c, v, bi;
        logic [63:0] ua, ub;
        longint      sa, sb, s;
        c  = st[1];
        v  = st[0];
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        bi = ~st[1];
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010, 4'b0011: begin
                s  = sa + sb + ((cmd == 4'b0011) ? longint'(st[1]) : 0);
                ub = ua + ub + ((cmd == 4'b0011) ? {63'd0, st[1]} : 64'd0);
                r  = ub[31:0];
                c  = ub > 64'hFFFF_FFFF;
                v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
                if (cmd == 4'b0100) bi = 1'b0;
                s = sa - sb - longint'(bi);
                r = a - b - {31'd0, bi};
                c = ua >= (ub + {63'd0, bi});
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: r = 32'd0;
        endcase
        nf = {r[31], (r == 32'd0), c, v};
    endfunction

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rm,
                         input logic [3:0] dst, input logic [4:0] ctl);
        valid_in    = 1'b1;
        exe_cmd     = cmd;
        val_rn      = a;
        val2        = b;
        val_rm      = rm;
        dest_in     = dst;
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in} = ctl;
    endtask

    // Model the instruction currently on the inputs with given operands.
    task automatic expect_op(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] rm);
        exp_t       e;
        logic [3:0] nf;
        logic [31:0] r;
        model(exe_cmd, a, b, m_status, r, nf);
        if (valid_in && !flush && s_in && !b_in) m_status = nf;
        e.v     = valid_in & ~flush;
        e.wb    = wb_en_in & e.v;
        e.mr    = mem_r_en_in & e.v;
        e.mw    = mem_w_en_in & e.v;
        e.full  = ~flush;
        e.res   = r;
        e.st    = rm;
        e.dst   = dest_in;
        e.flags = m_status;
        q.push_back(e);
    endtask

    task automatic step_check(input string tag);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_empty"}, 1, 0);
        end else begin
            last = q.pop_front();
            chk({tag, "_v"}, valid_out, last.v);
            chk({tag, "_ctl"}, {wb_en_out, mem_r_en_out, mem_w_en_out},
                {last.wb, last.mr, last.mw});
            chk({tag, "_st"}, status, last.flags);
            if (last.full) begin
                chk({tag, "_res"}, alu_res, last.res);
                chk({tag, "_sv"}, st_val, last.st);
                chk({tag, "_dst"}, dest_out, last.dst);
            end
        end
    endtask

    task automatic issue(input string tag, input logic [3:0] cmd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rm, input logic [3:0] dst,
                         input logic [4:0] ctl);
        drive(cmd, a, b, rm, dst, ctl);
        expect_op(a, b, rm);
        step_check(tag);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; valid_in = 1'b0;
        exe_cmd = 4'd0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        b_in = 0; s_in = 0; pc_in = 0; val_rn = 0; val2 = 0; val_rm = 0;
        imm24 = 0; dest_in = 0; sel_src1 = 0; sel_src2 = 0;
        mem_fwd = 0; wb_fwd = 0;
        m_status = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out,
                        alu_res, st_val, dest_out, status}, 0);
        rst = 1'b0;

        // ctl = {wb, mr, mw, b, s}
        issue("adds_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'd1, 5'b10001);
        chk("adds_nv", status, 4'b1001);
        issue("subs_eq", 4'b0100, 32'd5, 32'd5, 32'd0, 4'd2, 5'b10001);
        chk("subs_zc", status, 4'b0110);
        issue("sbc", 4'b0101, 32'd10, 32'd3, 32'd0, 4'd3, 5'b10000);
        chk("sbc_res", alu_res, 32'd7);
        issue("adds_c", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd4, 5'b10001);
        issue("adc", 4'b0011, 32'd1, 32'd1, 32'd0, 4'd5, 5'b10001);
        chk("adc_res", alu_res, 32'd3);
        issue("mvn", 4'b1001, 32'd0, 32'h0F0F_0000, 32'd0, 4'd6, 5'b10001);
        issue("and", 4'b0110, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 4'd7, 5'b10001);
        issue("orr", 4'b0111, 32'h1200_0000, 32'h0034_0000, 0, 4'd8, 5'b10000);
        issue("eor", 4'b1000, 32'hAAAA_5555, 32'hAAAA_5555, 0, 4'd9, 5'b10001);
        issue("bad", 4'b1111, 32'd9, 32'd9, 32'd0, 4'd10, 5'b10001);
        issue("subs_neg", 4'b0100, 32'h8000_0000, 32'd1, 0, 4'd11, 5'b10001);

        // Flushed load with S set must not write back or touch status.
        flush = 1'b1;
        drive(4'b0010, 32'h40, 32'h8, 32'd0, 4'd12, 5'b11001);
        expect_op(32'h40, 32'h8, 32'd0);
        step_check("flush_ldr");
        flush = 1'b0;

        issue("pre_frz", 4'b0010, 32'h10, 32'h20, 32'h55, 4'd13, 5'b10001);
        freeze = 1'b1;
        flush  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 32'h100 + i, 32'h1, 32'h77, 4'd14, 5'b10101);
            @(posedge clk);
            #1;
            chk("frz_hold", {valid_out, wb_en_out, mem_r_en_out,
                             mem_w_en_out, alu_res, st_val, dest_out, status},
                {last.v, last.wb, last.mr, last.mw, last.res, last.st,
                 last.dst, last.flags});
        end
        freeze = 1'b0;
        flush  = 1'b0;
        issue("frz_rel", 4'b0010, 32'h102, 32'h1, 32'h77, 4'd14, 5'b10101);

        // Branch with S set: target combinational, no flag write.
        pc_in = 32'h100;
        imm24 = 24'hFFFFFE;
        drive(4'b0000, 32'h0, 32'h0, 32'd0, 4'd0, 5'b00011);
        #1;
        chk("br_taken", branch_taken, 1'b1);
        chk("br_addr", branch_addr, 32'hF8);
        flush = 1'b1;
        #1;
        chk("br_flush", branch_taken, 1'b0);
        flush = 1'b0;
        expect_op(32'h0, 32'h0, 32'd0);
        step_check("br");
        pc_in = 32'hFFFF_FFF0;
        imm24 = 24'h000010;
        #1;
        chk("br_wrap", branch_addr, 32'h30);

        for (int i = 0; i < 12; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(1, 9));
            issue("rnd", c, $urandom, $urandom, $urandom, 4'(i),
                  {3'b100, 1'b0, 1'($urandom_range(0, 1))});
        end

        // Forwarding selects: honoured only in the forwarding build.
        sel_src1 = 2'd1;
        mem_fwd  = 32'h20;
        drive(4'b0010, 32'h1000, 32'h4, 32'h9, 4'd2, 5'b10000);
`ifdef FORWARDING_EN
        expect_op(32'h20, 32'h4, 32'h9);
`else
        expect_op(32'h1000, 32'h4, 32'h9);
`endif
        step_check("fwd1");
        sel_src1 = 2'd0;
        sel_src2 = 2'd2;
        wb_fwd   = 32'h300;
        drive(4'b0010, 32'h1, 32'h5, 32'h9, 4'd3, 5'b00100);
`ifdef FORWARDING_EN
        expect_op(32'h1, 32'h300, 32'h300);
`else
        expect_op(32'h1, 32'h5, 32'h9);
`endif
        step_check("fwd2");
        sel_src2 = 2'd0;

        // Async reset in the middle of a store.
        issue("str_pre", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'hBEEF, 4'd0, 5'b00101);
        chk("str_mw", mem_w_en_out, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {valid_out, mem_w_en_out, alu_res, status}, 0);
        #2;
        rst = 1'b0;
        m_status = 4'd0;
        issue("post_rst", 4'b0001, 32'd0, 32'd0, 32'd0, 4'd1, 5'b10001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
